// File: rtl/lfsr_ber_pkg.sv
// Shared constants and helpers for the LFSR bit-error-rate generator.
// Optional window error counter is enabled by defining LFSR_BER_ERRCNT_EN.
package lfsr_ber_pkg;

    localparam logic [31:0] TAPS_N8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_N16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_N32 = 32'h8020_0003;

    // Other widths fall back to the two top bits, which is always a legal tap mask.
    function automatic logic [31:0] defaultTaps(input int n);
        logic [31:0] taps;
        case (n)
            8:       taps = TAPS_N8;
            16:      taps = TAPS_N16;
            32:      taps = TAPS_N32;
            default: taps = (32'(1) << (n - 1)) | (32'(1) << (n - 2));
        endcase
        return taps;
    endfunction

    function automatic int countWidth(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// XNOR Fibonacci LFSR state register with all-ones lock-up escape and sticky flag.
// Seed loading shares the reset path; the caller decides which one wins.
module lfsr_core
    import lfsr_ber_pkg::*;
#(
    parameter int              N    = 8,
    parameter logic [N-1:0]    TAPS = N'(defaultTaps(N))
) (
    input  logic         clk,
    input  logic         i_load,
    input  logic [N-1:0] i_seed,
    input  logic         i_advance,
    output logic [N-1:0] o_state,
    output logic [N-1:0] o_next,
    output logic         o_lockup
);

    logic [N-1:0] r_state;
    logic         r_lockup;
    logic         w_feedback;
    logic         w_allOnes;
    logic [N-1:0] w_next;

    assign w_feedback = ~^(r_state & TAPS);
    assign w_allOnes  = &r_state;
    // All-ones is the XNOR dead state, so the step out of it is forced to zero.
    assign w_next     = w_allOnes ? '0 : {r_state[N-2:0], w_feedback};

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_state  <= i_seed;
            r_lockup <= 1'b0;
        end else if (i_advance) begin
            r_state <= w_next;
            if (w_allOnes) begin
                r_lockup <= 1'b1;
            end
        end
    end

    assign o_state  = r_state;
    assign o_next   = w_next;
    assign o_lockup = r_lockup;

endmodule

// File: rtl/lfsr_ber_gen.sv
// LFSR-driven bit-error generator with valid/ready output and threshold compare.
// Define LFSR_BER_ERRCNT_EN to build the per-window error counter.
module lfsr_ber_gen
    import lfsr_ber_pkg::*;
#(
    parameter int              N      = 8,
    parameter logic [N-1:0]    TAPS   = N'(defaultTaps(N)),
    parameter int              WINDOW = 256
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N-1:0]                        seed,
    input  logic                                seed_load,
    input  logic                                enable,
    input  logic [N-1:0]                        threshold,
    input  logic                                out_ready,
    output logic                                out_valid,
    output logic [N-1:0]                        rnd,
    output logic                                ber,
    output logic                                lockup,
    output logic [countWidth(WINDOW)-1:0]       err_count,
    output logic                                window_done
);

    localparam int CW = countWidth(WINDOW);

    logic         r_outValid;
    logic         r_ber;
    logic         w_advance;
    logic         w_load;
    logic [N-1:0] w_state;
    logic [N-1:0] w_next;
    logic         w_seedBer;
    logic         w_nextBer;

    // rst_n is active-high despite its name; reset and seed_load both reload the seed.
    assign w_load    = rst_n | seed_load;
    assign w_advance = enable & (~r_outValid | out_ready);

    // Widen by one bit so the compare stays unsigned for every N.
    assign w_seedBer = {1'b0, threshold} >= {1'b0, seed};
    assign w_nextBer = {1'b0, threshold} >= {1'b0, w_next};

    lfsr_core #(
        .N    (N),
        .TAPS (TAPS)
    ) u_core (
        .clk       (clk),
        .i_load    (w_load),
        .i_seed    (seed),
        .i_advance (w_advance),
        .o_state   (w_state),
        .o_next    (w_next),
        .o_lockup  (lockup)
    );

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_ber      <= w_seedBer;
            r_outValid <= 1'b0;
        end else if (w_advance) begin
            r_ber      <= w_nextBer;
            r_outValid <= 1'b1;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign rnd       = w_state;
    assign ber       = r_ber;

`ifdef LFSR_BER_ERRCNT_EN
    logic [CW-1:0] r_xferCount;
    logic [CW-1:0] r_acc;
    logic [CW-1:0] r_errCount;
    logic          r_windowDone;
    logic          w_transfer;

    assign w_transfer = r_outValid & out_ready;

    // A seed reload starts a fresh window but keeps the last completed result.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_xferCount  <= '0;
            r_acc        <= '0;
            r_errCount   <= '0;
            r_windowDone <= 1'b0;
        end else begin
            r_windowDone <= 1'b0;
            if (seed_load) begin
                r_xferCount <= '0;
                r_acc       <= '0;
            end else if (w_transfer) begin
                if (r_xferCount == CW'(WINDOW - 1)) begin
                    r_errCount   <= r_acc + CW'(r_ber);
                    r_windowDone <= 1'b1;
                    r_xferCount  <= '0;
                    r_acc        <= '0;
                end else begin
                    r_xferCount <= r_xferCount + CW'(1);
                    r_acc       <= r_acc + CW'(r_ber);
                end
            end
        end
    end

    assign err_count   = r_errCount;
    assign window_done = r_windowDone;
`else
    assign err_count   = '0;
    assign window_done = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_ber_gen.sv
// Directed testbench for lfsr_ber_gen (N=8, TAPS=0xB8, WINDOW=4).
// Window expectations follow whether LFSR_BER_ERRCNT_EN is defined.
module tb_lfsr_ber_gen;

`ifdef LFSR_BER_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] seed;
    logic       seed_load;
    logic       enable;
    logic [7:0] threshold;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] rnd;
    logic       ber;
    logic       lockup;
    logic [2:0] err_count;
    logic       window_done;

    int errors = 0;
    int checks = 0;

    lfsr_ber_gen #(
        .N      (8),
        .TAPS   (8'hB8),
        .WINDOW (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seed        (seed),
        .seed_load   (seed_load),
        .enable      (enable),
        .threshold   (threshold),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .rnd         (rnd),
        .ber         (ber),
        .lockup      (lockup),
        .err_count   (err_count),
        .window_done (window_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [7:0] s);
        rst_n     = 1'b1;
        seed      = s;
        seed_load = 1'b0;
        enable    = 1'b0;
        tick();
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        threshold = 8'd85;
        out_ready = 1'b0;
        doReset(8'h01);
        checks++; if (rnd !== 8'h01) begin errors++; $display("[TB] FAIL reset_rnd: got %h expected 01", rnd); end
        checks++; if (ber !== 1'b1) begin errors++; $display("[TB] FAIL reset_ber: got %b expected 1", ber); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (lockup !== 1'b0) begin errors++; $display("[TB] FAIL reset_lockup: got %b expected 0", lockup); end
        checks++; if (err_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_errcount: got %0d expected 0", err_count); end
        checks++; if (window_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", window_done); end
    endtask

    task automatic test_sequence();
        logic [7:0] expRnd [6] = '{8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D, 8'h7A};
        logic       expBer [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        threshold = 8'd85;
        doReset(8'h01);
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (rnd !== expRnd[i]) begin errors++; $display("[TB] FAIL seq_rnd%0d: got %h expected %h", i, rnd, expRnd[i]); end
            checks++; if (ber !== expBer[i]) begin errors++; $display("[TB] FAIL seq_ber%0d: got %b expected %b", i, ber, expBer[i]); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid%0d: got %b expected 1", i, out_valid); end
        end
        enable = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_validclr: got %b expected 0", out_valid); end
        checks++; if (rnd !== 8'h7A) begin errors++; $display("[TB] FAIL seq_hold: got %h expected 7a", rnd); end
    endtask

    task automatic test_compare();
        logic [7:0] seeds [4] = '{8'h00, 8'h07, 8'h07, 8'hFE};
        logic [7:0] thrs  [4] = '{8'h00, 8'h07, 8'h06, 8'hFF};
        logic       expB  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seed      = seeds[i];
            threshold = thrs[i];
            seed_load = 1'b1;
            tick();
            seed_load = 1'b0;
            checks++; if (ber !== expB[i]) begin errors++; $display("[TB] FAIL cmp_ber%0d: got %b expected %b", i, ber, expB[i]); end
        end
        threshold = 8'h05;
        seed      = 8'h01;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (ber !== 1'b1) begin errors++; $display("[TB] FAIL cmp_step03: got %b expected 1", ber); end
        tick();
        checks++; if (ber !== 1'b0) begin errors++; $display("[TB] FAIL cmp_step07: got %b expected 0", ber); end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        threshold = 8'd85;
        doReset(8'h01);
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (rnd !== 8'h03) begin errors++; $display("[TB] FAIL bp_rnd%0d: got %h expected 03", i, rnd); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid%0d: got %b expected 1", i, out_valid); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (rnd !== 8'h07) begin errors++; $display("[TB] FAIL bp_resume: got %h expected 07", rnd); end
        enable = 1'b0;
    endtask

    task automatic test_lockup();
        enable    = 1'b0;
        seed      = 8'hFF;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        checks++; if (rnd !== 8'hFF) begin errors++; $display("[TB] FAIL lk_load: got %h expected ff", rnd); end
        checks++; if (lockup !== 1'b0) begin errors++; $display("[TB] FAIL lk_pre: got %b expected 0", lockup); end
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (rnd !== 8'h00) begin errors++; $display("[TB] FAIL lk_escape: got %h expected 00", rnd); end
        checks++; if (lockup !== 1'b1) begin errors++; $display("[TB] FAIL lk_set: got %b expected 1", lockup); end
        tick();
        checks++; if (rnd !== 8'h01) begin errors++; $display("[TB] FAIL lk_from0: got %h expected 01", rnd); end
        checks++; if (lockup !== 1'b1) begin errors++; $display("[TB] FAIL lk_sticky: got %b expected 1", lockup); end
        enable    = 1'b0;
        seed      = 8'h01;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        checks++; if (lockup !== 1'b0) begin errors++; $display("[TB] FAIL lk_clear: got %b expected 0", lockup); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL lk_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_window();
        logic [2:0] exp4;
        logic       expDone;
        exp4 = ERRCNT ? 3'd4 : 3'd0;
        threshold = 8'hFF;
        doReset(8'h01);
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            expDone = (i == 5) ? ERRCNT : 1'b0;
            checks++; if (window_done !== expDone) begin errors++; $display("[TB] FAIL win1_done%0d: got %b expected %b", i, window_done, expDone); end
        end
        checks++; if (err_count !== exp4) begin errors++; $display("[TB] FAIL win1_count: got %0d expected %0d", err_count, exp4); end
        tick();
        checks++; if (window_done !== 1'b0) begin errors++; $display("[TB] FAIL win1_pulse: got %b expected 0", window_done); end
        enable    = 1'b0;
        threshold = 8'h00;
        seed      = 8'h01;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        checks++; if (err_count !== exp4) begin errors++; $display("[TB] FAIL win_stable: got %0d expected %0d", err_count, exp4); end
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            expDone = (i == 5) ? ERRCNT : 1'b0;
            checks++; if (window_done !== expDone) begin errors++; $display("[TB] FAIL win2_done%0d: got %b expected %b", i, window_done, expDone); end
            if (i < 5) begin
                checks++; if (err_count !== exp4) begin errors++; $display("[TB] FAIL win2_hold%0d: got %0d expected %0d", i, err_count, exp4); end
            end
        end
        checks++; if (err_count !== 3'd0) begin errors++; $display("[TB] FAIL win2_count: got %0d expected 0", err_count); end
        enable = 1'b0;
    endtask

    task automatic test_reset_priority();
        logic expDone;
        threshold = 8'hFF;
        doReset(8'h01);
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        rst_n     = 1'b1;
        seed_load = 1'b1;
        seed      = 8'h40;
        tick();
        rst_n     = 1'b0;
        seed_load = 1'b0;
        checks++; if (rnd !== 8'h40) begin errors++; $display("[TB] FAIL pri_rnd: got %h expected 40", rnd); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL pri_valid: got %b expected 0", out_valid); end
        checks++; if (err_count !== 3'd0) begin errors++; $display("[TB] FAIL pri_errcount: got %0d expected 0", err_count); end
        checks++; if (window_done !== 1'b0) begin errors++; $display("[TB] FAIL pri_done: got %b expected 0", window_done); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            expDone = (i == 5) ? ERRCNT : 1'b0;
            checks++; if (window_done !== expDone) begin errors++; $display("[TB] FAIL pri_win%0d: got %b expected %b", i, window_done, expDone); end
        end
        enable = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b1;
        seed      = 8'h01;
        seed_load = 1'b0;
        enable    = 1'b0;
        threshold = 8'd85;
        out_ready = 1'b0;
        test_reset();
        test_sequence();
        test_compare();
        test_backpressure();
        test_lockup();
        test_window();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
